// File: rtl/game_pkg.sv
// Shared game types for the battleship sequencer, board renderer and input logic.
package game_pkg;

  localparam int STATE_W           = 3;
  localparam int DEFAULT_MAX_SHIPS = 5;

  typedef enum logic [STATE_W-1:0] {
    DECISION    = 3'd0,
    COLOCATION  = 3'd1,
    SETUP       = 3'd2,
    PLAYER_TURN = 3'd3,
    PC_TURN     = 3'd4,
    VICTORY     = 3'd5,
    DEFEAT      = 3'd6
  } game_state_t;

  // One-hot flags ordered {defeat, victory, pc, player, setup, colocation, decision}.
  function automatic logic [6:0] state_flags(input game_state_t s);
    logic [6:0] f;
    f = 7'b000_0000;
    case (s)
      DECISION:    f = 7'b000_0001;
      COLOCATION:  f = 7'b000_0010;
      SETUP:       f = 7'b000_0100;
      PLAYER_TURN: f = 7'b000_1000;
      PC_TURN:     f = 7'b001_0000;
      VICTORY:     f = 7'b010_0000;
      DEFEAT:      f = 7'b100_0000;
      default:     f = 7'b000_0000;
    endcase
    return f;
  endfunction

endpackage

// File: rtl/turn_timer.sv
// Player-turn watchdog: counts enabled cycles and flags the last allowed one.
module turn_timer #(
  parameter int TIMEOUT_CYC = 750_000_000,
  parameter int TMR_W       = 30
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam logic [TMR_W-1:0] LAST = TMR_W'(TIMEOUT_CYC - 1);
  localparam logic [TMR_W-1:0] ONE  = TMR_W'(1);

  logic [TMR_W-1:0] cnt_q;
  logic [TMR_W-1:0] cnt_d;

  // Next count: clear wins, wrap after the final cycle so a stale count never lingers.
  always_comb begin
    cnt_d = cnt_q;
    if (clear) begin
      cnt_d = '0;
    end else if (enable) begin
      if (cnt_q == LAST) begin
        cnt_d = '0;
      end else begin
        cnt_d = cnt_q + ONE;
      end
    end else begin
      cnt_d = cnt_q;
    end
  end

  // Count register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign expired = enable && !clear && (cnt_q == LAST);

endmodule

// File: rtl/game_turn_ctrl.sv
// Battleship game sequencer: setup, alternating turns, win/loss and restart.
// Define TURN_TIMEOUT_EN to build in the player-turn timeout.
module game_turn_ctrl
  import game_pkg::*;
#(
  parameter int MAX_SHIPS   = DEFAULT_MAX_SHIPS,
  parameter int CNT_W       = $clog2(MAX_SHIPS + 1),
  parameter int TIMEOUT_CYC = 750_000_000,
  parameter int TMR_W       = 30
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [CNT_W-1:0]   ship_count_in,
  input  logic               count_valid,
  input  logic               place_confirm,
  input  logic               pc_setup_done,
  input  logic               player_fire,
  input  logic               player_sink,
  input  logic               pc_fire,
  input  logic               pc_sink,
  input  logic               new_game,
  output logic [STATE_W-1:0] state,
  output logic               decision_st,
  output logic               colocation_st,
  output logic               setup_st,
  output logic               player_st,
  output logic               pc_st,
  output logic               victory_st,
  output logic               defeat_st,
  output logic [CNT_W-1:0]   ships_to_place,
  output logic [CNT_W-1:0]   player_ships_left,
  output logic [CNT_W-1:0]   pc_ships_left,
  output logic [7:0]         round_cnt,
  output logic               timeout_pulse
);

  // An inconsistent parameter set refuses to start a game rather than misbehave.
  localparam bit CFG_OK = (MAX_SHIPS >= 1) && (MAX_SHIPS <= 15) && (TIMEOUT_CYC >= 1) &&
                          (TMR_W >= 1) && (TMR_W <= 62) &&
                          ((64'(TIMEOUT_CYC) - 64'd1) < (64'd1 << TMR_W));
  localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_SHIPS);
  localparam logic [CNT_W-1:0] ONE     = CNT_W'(1);

  game_state_t      state_q, state_d;
  logic [CNT_W-1:0] to_place_q, to_place_d;
  logic [CNT_W-1:0] player_left_q, player_left_d;
  logic [CNT_W-1:0] pc_left_q, pc_left_d;
  logic [7:0]       round_q, round_d;
  logic             timeout_pulse_q, timeout_pulse_d;
  logic             timer_expired_s;
  logic             count_ok_s;
  logic [7:0]       round_inc_s;

`ifdef TURN_TIMEOUT_EN
  logic timer_clear_s;
  logic timer_en_s;

  assign timer_en_s    = (state_q == PLAYER_TURN);
  assign timer_clear_s = (state_q != PLAYER_TURN);

  turn_timer #(
    .TIMEOUT_CYC (TIMEOUT_CYC),
    .TMR_W       (TMR_W)
  ) u_turn_timer (
    .clk     (clk),
    .rst     (rst),
    .clear   (timer_clear_s),
    .enable  (timer_en_s),
    .expired (timer_expired_s)
  );
`else
  assign timer_expired_s = 1'b0;
`endif

  assign count_ok_s  = CFG_OK && (ship_count_in != '0) && (ship_count_in <= MAX_CNT);
  assign round_inc_s = (round_q == 8'hFF) ? round_q : (round_q + 8'd1);

  // Next-state and counter updates; each strobe is honoured only in its own state.
  always_comb begin
    state_d         = state_q;
    to_place_d      = to_place_q;
    player_left_d   = player_left_q;
    pc_left_d       = pc_left_q;
    round_d         = round_q;
    timeout_pulse_d = 1'b0;
    case (state_q)
      DECISION: begin
        if (count_valid && count_ok_s) begin
          to_place_d    = ship_count_in;
          player_left_d = ship_count_in;
          pc_left_d     = ship_count_in;
          state_d       = COLOCATION;
        end else begin
          state_d = DECISION;
        end
      end
      COLOCATION: begin
        if (place_confirm) begin
          to_place_d = (to_place_q != '0) ? (to_place_q - ONE) : '0;
          state_d    = (to_place_q == ONE) ? SETUP : COLOCATION;
        end else begin
          state_d = COLOCATION;
        end
      end
      SETUP: begin
        if (pc_setup_done) begin
          state_d = PLAYER_TURN;
          round_d = round_inc_s;
        end else begin
          state_d = SETUP;
        end
      end
      PLAYER_TURN: begin
        // A shot in the expiry cycle still counts as a normal turn.
        if (player_fire) begin
          pc_left_d = (player_sink && (pc_left_q != '0)) ? (pc_left_q - ONE) : pc_left_q;
          state_d   = (player_sink && (pc_left_q == ONE)) ? VICTORY : PC_TURN;
        end else if (timer_expired_s) begin
          state_d         = PC_TURN;
          timeout_pulse_d = 1'b1;
        end else begin
          state_d = PLAYER_TURN;
        end
      end
      PC_TURN: begin
        if (pc_fire) begin
          player_left_d = (pc_sink && (player_left_q != '0)) ? (player_left_q - ONE) : player_left_q;
          if (pc_sink && (player_left_q == ONE)) begin
            state_d = DEFEAT;
          end else begin
            state_d = PLAYER_TURN;
            round_d = round_inc_s;
          end
        end else begin
          state_d = PC_TURN;
        end
      end
      VICTORY, DEFEAT: begin
        if (new_game) begin
          state_d       = DECISION;
          to_place_d    = '0;
          player_left_d = '0;
          pc_left_d     = '0;
          round_d       = 8'd0;
        end else begin
          state_d = state_q;
        end
      end
      default: begin
        state_d       = DECISION;
        to_place_d    = '0;
        player_left_d = '0;
        pc_left_d     = '0;
        round_d       = 8'd0;
      end
    endcase
  end

  // State and counter registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q         <= DECISION;
      to_place_q      <= '0;
      player_left_q   <= '0;
      pc_left_q       <= '0;
      round_q         <= 8'd0;
      timeout_pulse_q <= 1'b0;
    end else begin
      state_q         <= state_d;
      to_place_q      <= to_place_d;
      player_left_q   <= player_left_d;
      pc_left_q       <= pc_left_d;
      round_q         <= round_d;
      timeout_pulse_q <= timeout_pulse_d;
    end
  end

  assign state             = state_q;
  assign {defeat_st, victory_st, pc_st, player_st, setup_st, colocation_st, decision_st} =
         state_flags(state_q);
  assign ships_to_place    = to_place_q;
  assign player_ships_left = player_left_q;
  assign pc_ships_left     = pc_left_q;
  assign round_cnt         = round_q;
  assign timeout_pulse     = timeout_pulse_q;

endmodule

// File: tb/tb_game_turn_ctrl.sv
// Self-checking bench for game_turn_ctrl: directed game scenarios then random play
// against a behavioural model. Timeout checks follow TURN_TIMEOUT_EN.
module tb_game_turn_ctrl;

  localparam int MAX_SHIPS   = 5;
  localparam int CNT_W       = 3;
  localparam int TIMEOUT_CYC = 10;
  localparam int TMR_W       = 4;
`ifdef TURN_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif

  localparam int ST_DEC = 0, ST_COL = 1, ST_SET = 2, ST_PLY = 3, ST_PC = 4, ST_VIC = 5, ST_DEF = 6;

  logic             clk = 1'b0;
  logic             rst = 1'b0;
  logic [CNT_W-1:0] ship_count_in;
  logic             count_valid, place_confirm, pc_setup_done;
  logic             player_fire, player_sink, pc_fire, pc_sink, new_game;
  logic [2:0]       state;
  logic             decision_st, colocation_st, setup_st, player_st, pc_st, victory_st, defeat_st;
  logic [CNT_W-1:0] ships_to_place, player_ships_left, pc_ships_left;
  logic [7:0]       round_cnt;
  logic             timeout_pulse;

  game_turn_ctrl #(
    .MAX_SHIPS   (MAX_SHIPS),
    .CNT_W       (CNT_W),
    .TIMEOUT_CYC (TIMEOUT_CYC),
    .TMR_W       (TMR_W)
  ) dut (
    .clk               (clk),
    .rst               (rst),
    .ship_count_in     (ship_count_in),
    .count_valid       (count_valid),
    .place_confirm     (place_confirm),
    .pc_setup_done     (pc_setup_done),
    .player_fire       (player_fire),
    .player_sink       (player_sink),
    .pc_fire           (pc_fire),
    .pc_sink           (pc_sink),
    .new_game          (new_game),
    .state             (state),
    .decision_st       (decision_st),
    .colocation_st     (colocation_st),
    .setup_st          (setup_st),
    .player_st         (player_st),
    .pc_st             (pc_st),
    .victory_st        (victory_st),
    .defeat_st         (defeat_st),
    .ships_to_place    (ships_to_place),
    .player_ships_left (player_ships_left),
    .pc_ships_left     (pc_ships_left),
    .round_cnt         (round_cnt),
    .timeout_pulse     (timeout_pulse)
  );

  always #5 clk = ~clk;

  // Model: current expectation (m_*) and next-cycle expectation (n_*).
  int m_st, m_place, m_pl, m_pc, m_round, m_pulse, m_age;
  int n_st, n_place, n_pl, n_pc, n_round, n_pulse, n_age;
  int pass_cnt  = 0;
  int total_cnt = 0;

  task automatic chk(input string name, input int act, input int exp);
    total_cnt++;
    if (act == exp) pass_cnt++;
    else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
  endtask

  task automatic clear_inputs();
    ship_count_in = 3'd0; count_valid = 1'b0; place_confirm = 1'b0; pc_setup_done = 1'b0;
    player_fire = 1'b0; player_sink = 1'b0; pc_fire = 1'b0; pc_sink = 1'b0; new_game = 1'b0;
  endtask

  task automatic model_reset();
    m_st = ST_DEC; m_place = 0; m_pl = 0; m_pc = 0; m_round = 0; m_pulse = 0; m_age = 0;
  endtask

  task automatic model_next();
    int sc;
    sc = int'(ship_count_in);
    n_st = m_st; n_place = m_place; n_pl = m_pl; n_pc = m_pc; n_round = m_round; n_pulse = 0;
    case (m_st)
      ST_DEC: if (count_valid && sc >= 1 && sc <= MAX_SHIPS) begin
        n_place = sc; n_pl = sc; n_pc = sc; n_st = ST_COL;
      end
      ST_COL: if (place_confirm) begin
        n_place = (m_place > 0) ? m_place - 1 : 0;
        if (m_place == 1) n_st = ST_SET;
      end
      ST_SET: if (pc_setup_done) n_st = ST_PLY;
      ST_PLY: if (player_fire) begin
        if (player_sink && m_pc > 0) n_pc = m_pc - 1;
        n_st = (player_sink && m_pc == 1) ? ST_VIC : ST_PC;
      end else if (TO_EN && m_age == TIMEOUT_CYC - 1) begin
        n_st = ST_PC; n_pulse = 1;
      end
      ST_PC: if (pc_fire) begin
        if (pc_sink && m_pl > 0) n_pl = m_pl - 1;
        n_st = (pc_sink && m_pl == 1) ? ST_DEF : ST_PLY;
      end
      ST_VIC, ST_DEF: if (new_game) begin
        n_st = ST_DEC; n_place = 0; n_pl = 0; n_pc = 0; n_round = 0;
      end
      default: n_st = ST_DEC;
    endcase
    if (n_st == ST_PLY && m_st != ST_PLY && m_round < 255) n_round = m_round + 1;
    n_age = (m_st == ST_PLY && n_st == ST_PLY) ? m_age + 1 : 0;
  endtask

  task automatic compare_all();
    chk("state", int'(state), m_st);
    chk("decision_st", int'(decision_st), int'(m_st == ST_DEC));
    chk("colocation_st", int'(colocation_st), int'(m_st == ST_COL));
    chk("setup_st", int'(setup_st), int'(m_st == ST_SET));
    chk("player_st", int'(player_st), int'(m_st == ST_PLY));
    chk("pc_st", int'(pc_st), int'(m_st == ST_PC));
    chk("victory_st", int'(victory_st), int'(m_st == ST_VIC));
    chk("defeat_st", int'(defeat_st), int'(m_st == ST_DEF));
    chk("ships_to_place", int'(ships_to_place), m_place);
    chk("player_ships_left", int'(player_ships_left), m_pl);
    chk("pc_ships_left", int'(pc_ships_left), m_pc);
    chk("round_cnt", int'(round_cnt), m_round);
    chk("timeout_pulse", int'(timeout_pulse), m_pulse);
  endtask

  // Called just after a negedge with inputs already set; ends after the next negedge.
  task automatic step();
    model_next();
    @(posedge clk);
    m_st = n_st; m_place = n_place; m_pl = n_pl; m_pc = n_pc;
    m_round = n_round; m_pulse = n_pulse; m_age = n_age;
    @(negedge clk);
    compare_all();
    clear_inputs();
  endtask

  task automatic async_reset();
    #2;
    rst = 1'b0;
    #1;
    model_reset();
    compare_all();
    chk("async_rst_state", int'(state), 0);
    @(negedge clk);
    compare_all();
    rst = 1'b1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not complete, got time %0t expected finish", $time);
    $fatal(1);
  end

  initial begin
    clear_inputs();
    model_reset();
    rst = 1'b0;
    repeat (2) @(negedge clk);
    compare_all();
    chk("lit_reset_state", int'(state), 0);
    chk("lit_reset_decision_st", int'(decision_st), 1);
    chk("lit_reset_round", int'(round_cnt), 0);
    rst = 1'b1;

    // Out-of-range counts are ignored, then a 3-ship game starts.
    count_valid = 1'b1; ship_count_in = 3'd0; step();
    chk("lit_cnt0_ignored", int'(state), 0);
    count_valid = 1'b1; ship_count_in = 3'd6; step();
    chk("lit_cnt6_ignored", int'(state), 0);
    count_valid = 1'b1; ship_count_in = 3'd3; step();
    chk("lit_coloc_state", int'(state), 1);
    chk("lit_load_place", int'(ships_to_place), 3);
    chk("lit_load_player", int'(player_ships_left), 3);
    chk("lit_load_pc", int'(pc_ships_left), 3);
    place_confirm = 1'b1; step();
    chk("lit_place_2", int'(ships_to_place), 2);
    place_confirm = 1'b1; step();
    chk("lit_place_1", int'(ships_to_place), 1);
    place_confirm = 1'b1; step();
    chk("lit_place_0", int'(ships_to_place), 0);
    chk("lit_setup_state", int'(state), 2);
    pc_setup_done = 1'b1; step();
    chk("lit_player_state", int'(state), 3);
    chk("lit_round_1", int'(round_cnt), 1);
    player_fire = 1'b1; step();
    chk("lit_pc_turn", int'(state), 4);
    chk("lit_pc_left_3", int'(pc_ships_left), 3);
    pc_fire = 1'b1; pc_sink = 1'b1; step();
    chk("lit_back_player", int'(state), 3);
    chk("lit_player_left_2", int'(player_ships_left), 2);
    chk("lit_round_2", int'(round_cnt), 2);
    player_fire = 1'b1; player_sink = 1'b1; step();
    chk("lit_pc_left_2", int'(pc_ships_left), 2);
    async_reset();
    chk("lit_rst_round", int'(round_cnt), 0);
    chk("lit_rst_player_left", int'(player_ships_left), 0);

    // One-ship game won on the first shot.
    count_valid = 1'b1; ship_count_in = 3'd1; step();
    place_confirm = 1'b1; step();
    pc_setup_done = 1'b1; step();
    player_fire = 1'b1; player_sink = 1'b1; step();
    chk("lit_victory", int'(state), 5);
    chk("lit_victory_pc_left", int'(pc_ships_left), 0);
    new_game = 1'b1; step();
    chk("lit_newgame_state", int'(state), 0);
    chk("lit_newgame_round", int'(round_cnt), 0);

    // Two-ship game lost to the PC; later PC shots are ignored.
    count_valid = 1'b1; ship_count_in = 3'd2; step();
    place_confirm = 1'b1; step();
    place_confirm = 1'b1; step();
    pc_setup_done = 1'b1; step();
    player_fire = 1'b1; step();
    pc_fire = 1'b1; pc_sink = 1'b1; step();
    chk("lit_defeat_left_1", int'(player_ships_left), 1);
    player_fire = 1'b1; step();
    pc_fire = 1'b1; pc_sink = 1'b1; step();
    chk("lit_defeat", int'(state), 6);
    chk("lit_defeat_left_0", int'(player_ships_left), 0);
    pc_fire = 1'b1; pc_sink = 1'b1; step();
    chk("lit_defeat_hold", int'(state), 6);
    new_game = 1'b1; step();

    // Idle player turn.
    count_valid = 1'b1; ship_count_in = 3'd2; step();
    place_confirm = 1'b1; step();
    place_confirm = 1'b1; step();
    pc_setup_done = 1'b1; step();
    repeat (9) step();
    chk("lit_idle_9", int'(state), 3);
    step();
`ifdef TURN_TIMEOUT_EN
    chk("lit_timeout_state", int'(state), 4);
    chk("lit_timeout_pulse", int'(timeout_pulse), 1);
    step();
    chk("lit_timeout_pulse_drop", int'(timeout_pulse), 0);
    pc_fire = 1'b1; step();
    repeat (9) step();
    player_fire = 1'b1; step();
    chk("lit_fire_wins_state", int'(state), 4);
    chk("lit_fire_wins_pulse", int'(timeout_pulse), 0);
`else
    chk("lit_no_timeout_state", int'(state), 3);
    chk("lit_no_timeout_pulse", int'(timeout_pulse), 0);
    player_fire = 1'b1; step();
    chk("lit_fire_late", int'(state), 4);
`endif

    // Random play, with occasional asynchronous resets.
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 399) == 0) begin
        async_reset();
      end else begin
        count_valid   = ($urandom_range(0, 2) == 0);
        ship_count_in = CNT_W'($urandom_range(0, 7));
        place_confirm = ($urandom_range(0, 1) == 0);
        pc_setup_done = ($urandom_range(0, 3) == 0);
        player_fire   = ($urandom_range(0, 11) == 0);
        player_sink   = ($urandom_range(0, 1) == 1);
        pc_fire       = ($urandom_range(0, 2) == 0);
        pc_sink       = ($urandom_range(0, 1) == 1);
        new_game      = ($urandom_range(0, 5) == 0);
        step();
      end
    end

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
